// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one word-aligned request at a time, and holds the returned word for decode.
// Optional misaligned-redirect trap is enabled with `define FETCH_MISALIGN_CHK_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_misaligned,
  output logic [2:0]  dbg_state
);

  // Handshakes: a request transfers when imem_req_valid && imem_req_ready on a rising edge;
  // the response is a single-cycle imem_rsp_valid strobe (no backpressure); decode takes the
  // held word when instr_valid && instr_ready, and the outputs stay frozen until then.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    FULL = 3'd3,
    DROP = 3'd4,
    TRAP = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        trap_pend;
  logic [31:0] tgt;
  logic        tgt_bad;
  logic        in_flight;

`ifdef FETCH_MISALIGN_CHK_EN
  assign tgt     = redirect_pc;
  assign tgt_bad = |redirect_pc[1:0];
`else
  assign tgt     = redirect_pc & ~32'h0000_0003;
  assign tgt_bad = 1'b0;
`endif

  // A response is still owed by memory if one was accepted and not yet returned.
  assign in_flight = (state == WAIT) || (state == DROP) ||
                     ((state == REQ) && imem_req_ready);

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign dbg_state      = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      pc               <= RESET_PC;
      instruction      <= NOP_INSTR;
      instr_pc         <= RESET_PC;
      instr_valid      <= 1'b0;
      fetch_misaligned <= 1'b0;
      trap_pend        <= 1'b0;
    end else if (redirect_valid && (state != IDLE)) begin
      pc          <= tgt;
      instr_valid <= 1'b0;
      instruction <= NOP_INSTR;
      if (in_flight) begin
        // A misaligned target seen here only traps once the stale word is flushed.
        state            <= DROP;
        trap_pend        <= tgt_bad;
        fetch_misaligned <= 1'b0;
      end else if (tgt_bad) begin
        state            <= TRAP;
        trap_pend        <= 1'b0;
        fetch_misaligned <= 1'b1;
      end else begin
        state            <= REQ;
        trap_pend        <= 1'b0;
        fetch_misaligned <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            state       <= FULL;
            instruction <= imem_rsp_data;
            instr_pc    <= pc;
            pc          <= pc + 32'd4;
            instr_valid <= 1'b1;
          end
        end
        FULL: begin
          if (instr_ready) begin
            state       <= REQ;
            instr_valid <= 1'b0;
            instruction <= NOP_INSTR;
          end
        end
        DROP: begin
          if (imem_rsp_valid) begin
            if (trap_pend) begin
              state            <= TRAP;
              fetch_misaligned <= 1'b1;
              trap_pend        <= 1'b0;
            end else begin
              state <= REQ;
            end
          end
        end
        TRAP: state <= TRAP;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: zero-wait memory model, scoreboard of expected {instr_pc, instruction}.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_misaligned;
  logic [2:0]  dbg_state;

  // memory model controls
  logic        mem_en;
  logic        auto_valid;
  logic [31:0] auto_data;
  logic        man_valid;
  logic [31:0] man_data;
  logic        acc;
  logic [31:0] acc_addr;

  logic [63:0] exp_q[$];
  logic [63:0] exp_item;
  int checks_total;
  int checks_passed;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instruction(instruction), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .fetch_misaligned(fetch_misaligned), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rsp_valid = mem_en ? auto_valid : man_valid;
  assign imem_rsp_data  = mem_en ? auto_data  : man_data;

  // zero-wait memory: answers the cycle after acceptance with addr ^ XOR_PAT
  initial begin
    auto_valid = 1'b0;
    auto_data  = '0;
    acc        = 1'b0;
    acc_addr   = '0;
    forever begin
      @(negedge clk);
      acc      = imem_req_valid && imem_req_ready && !rst;
      acc_addr = imem_req_addr;
      @(posedge clk);
      #1;
      auto_valid = acc;
      auto_data  = acc ? (acc_addr ^ XOR_PAT) : 32'h0;
    end
  end

  // scoreboard: every decode handshake pops one expected {instr_pc, instruction}
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready && !redirect_valid) begin
      checks_total = checks_total + 1;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got pc=%h instr=%h, required no consumption", instr_pc, instruction);
      end else begin
        exp_item = exp_q.pop_front();
        if ({instr_pc, instruction} !== exp_item)
          $display("FAIL sb_consume: got pc=%h instr=%h, required pc=%h instr=%h",
                   instr_pc, instruction, exp_item[63:32], exp_item[31:0]);
        else
          checks_passed = checks_passed + 1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;
    mem_en         = 1'b1;
    man_valid      = 1'b0;
    man_data       = '0;
    tick();
    tick();
    rst = 1'b0;   // now in cycle 0
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks_total = checks_total + 1;
    if ({imem_req_valid, imem_req_addr} !== {1'b0, 32'h0})
      $display("FAIL reset_req: got %b/%h, required 0/00000000", imem_req_valid, imem_req_addr);
    else checks_passed = checks_passed + 1;
    checks_total = checks_total + 1;
    if (instruction !== NOP)
      $display("FAIL reset_instr: got %h, required %h", instruction, NOP);
    else checks_passed = checks_passed + 1;
    checks_total = checks_total + 1;
    if ({instr_valid, instr_pc, fetch_misaligned} !== {1'b0, 32'h0, 1'b0})
      $display("FAIL reset_valid_pc: got v=%b pc=%h mis=%b, required 0/0/0", instr_valid, instr_pc, fetch_misaligned);
    else checks_passed = checks_passed + 1;
  endtask

  task automatic test_sequential();
    logic [31:0] epc;
    do_reset();
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      epc = 32'(k * 4);
      exp_q.push_back({epc, epc ^ XOR_PAT});
    end
    for (int c = 1; c <= 9; c++) begin
      tick();
      checks_total = checks_total + 1;
      if ((c % 3) == 0) begin
        epc = 32'((c / 3 - 1) * 4);
        if ({instr_valid, instr_pc} !== {1'b1, epc})
          $display("FAIL seq_cycle%0d: got v=%b pc=%h, required 1/%h", c, instr_valid, instr_pc, epc);
        else checks_passed = checks_passed + 1;
      end else begin
        if (instr_valid !== 1'b0)
          $display("FAIL seq_cycle%0d: got v=%b, required 0", c, instr_valid);
        else checks_passed = checks_passed + 1;
      end
    end
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick(); tick();
    exp_q.push_back({32'h0, XOR_PAT});
    for (int c = 0; c < 5; c++) begin
      tick();
      checks_total = checks_total + 1;
      if ({instr_valid, instr_pc, instruction, imem_req_valid} !== {1'b1, 32'h0, XOR_PAT, 1'b0})
        $display("FAIL stall_hold%0d: got v=%b pc=%h instr=%h req=%b, required 1/0/%h/0",
                 c, instr_valid, instr_pc, instruction, imem_req_valid, XOR_PAT);
      else checks_passed = checks_passed + 1;
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks_total = checks_total + 1;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h4})
      $display("FAIL stall_release_req: got %b/%h, required 1/00000004", imem_req_valid, imem_req_addr);
    else checks_passed = checks_passed + 1;
    tick(); tick();
    checks_total = checks_total + 1;
    if ({instr_valid, instr_pc, instruction} !== {1'b1, 32'h4, 32'h4 ^ XOR_PAT})
      $display("FAIL stall_next: got v=%b pc=%h instr=%h, required 1/4/%h", instr_valid, instr_pc, instruction, 32'h4 ^ XOR_PAT);
    else checks_passed = checks_passed + 1;
  endtask

  task automatic test_redirect_wait();
    do_reset();
    mem_en = 1'b0;
    tick();          // cycle 1: REQ accepted
    tick();          // cycle 2: WAIT
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();          // cycle 3: DROP
    redirect_valid = 1'b0;
    checks_total = checks_total + 1;
    if ({imem_req_valid, imem_req_addr} !== {1'b0, 32'h100})
      $display("FAIL drop_noreq: got %b/%h, required 0/00000100", imem_req_valid, imem_req_addr);
    else checks_passed = checks_passed + 1;
    man_valid = 1'b1;
    man_data  = 32'hDEAD_BEEF;
    tick();          // cycle 4: stale word discarded
    man_valid = 1'b0;
    checks_total = checks_total + 1;
    if ({imem_req_valid, imem_req_addr, instr_valid, instruction} !== {1'b1, 32'h100, 1'b0, NOP})
      $display("FAIL drop_discard: got req=%b addr=%h v=%b instr=%h, required 1/100/0/%h",
               imem_req_valid, imem_req_addr, instr_valid, instruction, NOP);
    else checks_passed = checks_passed + 1;
    mem_en      = 1'b1;
    instr_ready = 1'b1;
    exp_q.push_back({32'h100, 32'h100 ^ XOR_PAT});
    tick(); tick();  // cycle 6: FULL
    checks_total = checks_total + 1;
    if ({instr_valid, instr_pc} !== {1'b1, 32'h100})
      $display("FAIL drop_refetch: got v=%b pc=%h, required 1/00000100", instr_valid, instr_pc);
    else checks_passed = checks_passed + 1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_redirect_full();
    do_reset();
    tick(); tick(); tick();    // cycle 3: FULL, pc 0 held
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    instr_ready    = 1'b1;
    tick();
    redirect_valid = 1'b0;
    checks_total = checks_total + 1;
    if ({instr_valid, instruction, imem_req_valid, imem_req_addr} !== {1'b0, NOP, 1'b1, 32'h40})
      $display("FAIL rfull_redirect: got v=%b instr=%h req=%b addr=%h, required 0/%h/1/00000040",
               instr_valid, instruction, imem_req_valid, imem_req_addr, NOP);
    else checks_passed = checks_passed + 1;
    exp_q.push_back({32'h40, 32'h40 ^ XOR_PAT});
    tick(); tick();
    checks_total = checks_total + 1;
    if ({instr_valid, instr_pc} !== {1'b1, 32'h40})
      $display("FAIL rfull_target: got v=%b pc=%h, required 1/00000040", instr_valid, instr_pc);
    else checks_passed = checks_passed + 1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_misaligned();
    do_reset();
    tick(); tick(); tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    for (int c = 0; c < 3; c++) begin
      checks_total = checks_total + 1;
      if ({fetch_misaligned, imem_req_valid, instr_valid} !== 3'b100)
        $display("FAIL trap_hold%0d: got mis=%b req=%b v=%b, required 1/0/0", c, fetch_misaligned, imem_req_valid, instr_valid);
      else checks_passed = checks_passed + 1;
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    checks_total = checks_total + 1;
    if ({fetch_misaligned, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h200})
      $display("FAIL trap_exit: got mis=%b req=%b addr=%h, required 0/1/00000200", fetch_misaligned, imem_req_valid, imem_req_addr);
    else checks_passed = checks_passed + 1;
    instr_ready = 1'b1;
    exp_q.push_back({32'h200, 32'h200 ^ XOR_PAT});
    tick(); tick();
    checks_total = checks_total + 1;
    if ({instr_valid, instr_pc} !== {1'b1, 32'h200})
      $display("FAIL trap_fetch: got v=%b pc=%h, required 1/00000200", instr_valid, instr_pc);
    else checks_passed = checks_passed + 1;
`else
    checks_total = checks_total + 1;
    if ({fetch_misaligned, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h100})
      $display("FAIL align_force: got mis=%b req=%b addr=%h, required 0/1/00000100", fetch_misaligned, imem_req_valid, imem_req_addr);
    else checks_passed = checks_passed + 1;
    instr_ready = 1'b1;
    exp_q.push_back({32'h100, 32'h100 ^ XOR_PAT});
    tick(); tick();
    checks_total = checks_total + 1;
    if ({instr_valid, instr_pc} !== {1'b1, 32'h100})
      $display("FAIL align_fetch: got v=%b pc=%h, required 1/00000100", instr_valid, instr_pc);
    else checks_passed = checks_passed + 1;
`endif
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    tick(); tick(); tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    instr_ready    = 1'b1;
    tick();
    redirect_valid = 1'b0;
    exp_q.push_back({32'hFFFF_FFFC, 32'hFFFF_FFFC ^ XOR_PAT});
    tick(); tick();
    checks_total = checks_total + 1;
    if ({instr_valid, instr_pc} !== {1'b1, 32'hFFFF_FFFC})
      $display("FAIL wrap_top: got v=%b pc=%h, required 1/fffffffc", instr_valid, instr_pc);
    else checks_passed = checks_passed + 1;
    tick();
    instr_ready = 1'b0;
    checks_total = checks_total + 1;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0})
      $display("FAIL wrap_addr: got %b/%h, required 1/00000000", imem_req_valid, imem_req_addr);
    else checks_passed = checks_passed + 1;
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    instr_ready = 1'b1;
    exp_q.push_back({32'h0, XOR_PAT});
    tick(); tick(); tick(); tick(); tick();  // cycle 5: WAIT on address 4
    mem_en      = 1'b0;
    instr_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks_total = checks_total + 1;
    if ({imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc, fetch_misaligned} !==
        {1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0})
      $display("FAIL async_reset: got req=%b addr=%h v=%b instr=%h pc=%h mis=%b, required 0/0/0/%h/0/0",
               imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc, fetch_misaligned, NOP);
    else checks_passed = checks_passed + 1;
    tick();
    rst       = 1'b0;   // cycle 0
    man_valid = 1'b1;   // late response arriving in IDLE then REQ
    man_data  = 32'hDEAD_BEEF;
    tick();
    checks_total = checks_total + 1;
    if ({imem_req_valid, imem_req_addr, instr_valid} !== {1'b1, 32'h0, 1'b0})
      $display("FAIL late_rsp_req: got req=%b addr=%h v=%b, required 1/0/0", imem_req_valid, imem_req_addr, instr_valid);
    else checks_passed = checks_passed + 1;
    man_valid = 1'b0;
    tick(); tick();
    checks_total = checks_total + 1;
    if ({instr_valid, instruction} !== {1'b0, NOP})
      $display("FAIL late_rsp_ignored: got v=%b instr=%h, required 0/%h", instr_valid, instruction, NOP);
    else checks_passed = checks_passed + 1;
  endtask

  initial begin
    checks_total   = 0;
    checks_passed  = 0;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;
    mem_en         = 1'b1;
    man_valid      = 1'b0;
    man_data       = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_full();
    test_misaligned();
    test_wrap();
    test_reset_in_wait();
    checks_total = checks_total + 1;
    if (exp_q.size() !== 0)
      $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
    else checks_passed = checks_passed + 1;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
